// File: rtl/mult_booth.sv
// Sequential signed 32x32 radix-2 Booth multiplier; one Booth step per clock,
// 64-bit product presented as registered hi/lo with a one-cycle done pulse.
module mult_booth (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic signed [32:0] acc, m;
  logic [31:0]        q;
  logic               q_1;
  logic [5:0]         count;

  logic signed [32:0] acc_sum, acc_sh;
  logic [31:0]        q_sh;
  logic               accept, last_step;

  // Add/subtract selection for one radix-2 Booth step; the 33-bit width keeps
  // A - M exact when M is the most negative 32-bit value.
  function automatic logic signed [32:0] booth_add(input logic [1:0] sel,
                                                   input logic signed [32:0] acc_v,
                                                   input logic signed [32:0] m_v);
    case (sel)
      2'b01:   return acc_v + m_v;
      2'b10:   return acc_v - m_v;
      default: return acc_v;
    endcase
  endfunction

  always_comb begin
    acc_sum   = booth_add({q[0], q_1}, acc, m);
    acc_sh    = {acc_sum[32], acc_sum[32:1]};
    q_sh      = {acc_sum[0], q[31:1]};
    accept    = start && (state == IDLE || state == DONE);
    last_step = (state == RUN) && (count == 6'd31);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == 6'd31) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc   <= '0;
        m     <= $signed({a[31], a});
        q     <= b;
        q_1   <= 1'b0;
        count <= '0;
      end else if (state == RUN) begin
        acc   <= acc_sh;
        q     <= q_sh;
        q_1   <= q[0];
        count <= count + 6'd1;
      end
      // Result is taken from the post-shift values of the 32nd step.
      if (last_step) begin
        hi <= acc_sh[31:0];
        lo <= q_sh;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: directed vector table, busy/reset
// sequences and a randomized regression against a 64-bit signed product.
module tb_mult_booth;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  mult_booth dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic launch(input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   lat;
    logic seen_done;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000};
    vecs[5] = '{32'd0,        32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_hi",   64'(hi),   64'h0);
    chk("reset_lo",   64'(lo),   64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].va, vecs[i].vb);
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'h1);
      wait_done(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
      chk($sformatf("vec%0d_prod", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
      chk($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'h0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'h0);
    end

    // Busy protection: start ignored in RUN, operand changes ignored.
    launch(32'd7, 32'd6);
    seen_done = 1'b0;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      a     = $urandom;
      b     = $urandom;
      start = (k == 10);
      if (k == 10) begin
        a = 32'd9;
        b = 32'd9;
      end
    end
    start = 1'b0;
    chk("busy_no_early_done", 64'(seen_done), 64'h0);
    chk("busy_hold_lo", 64'(lo), 64'h0);
    @(negedge clk);
    chk("busy_done", 64'(done), 64'h1);
    chk("busy_prod", {hi, lo}, 64'h0000_0000_0000_002A);
    launch(32'hFFFF_FFFC, 32'd5);
    chk("b2b_no_double_done", 64'(done), 64'h0);
    wait_done(lat);
    chk("b2b_gap", 64'(lat + 1), 64'd33);
    chk("b2b_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEC);
    @(negedge clk);

    // Reset mid-operation aborts without a done.
    launch(32'd2, 32'd2);
    wait_done(lat);
    chk("pre_reset_prod", {hi, lo}, 64'h4);
    @(negedge clk);
    launch(32'd10, 32'd10);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_hi",   64'(hi),   64'h0);
    chk("midreset_lo",   64'(lo),   64'h0);
    chk("midreset_busy", 64'(busy), 64'h0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("midreset_no_done", 64'(seen_done), 64'h0);
    launch(32'd10, 32'd10);
    wait_done(lat);
    chk("post_reset_latency", 64'(lat), 64'd32);
    chk("post_reset_prod", {hi, lo}, 64'h64);
    @(negedge clk);

    // Random regression; about half the operations start in the DONE cycle.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h7FFF_FFFF;
        default: ;
      endcase
      launch(ra, rb);
      wait_done(lat);
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd32);
      chk($sformatf("rand%0d_prod a=%h b=%h", i, ra, rb), {hi, lo}, ref_prod(ra, rb));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_booth.md
# mult_booth

Sequential signed 32x32 multiplier for the multicycle datapath. It implements radix-2 Booth and produces a 64-bit product split into `hi` and `lo`. The outputs feed the HI and LO sources of the register-write data select stage. The control unit starts it with a one-cycle `start` and waits for `done` before selecting HI or LO.

## Interface
Parameters: none. Width is fixed at 32 bits per operand.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- `start`  input  1  request to begin a multiply; sampled only in IDLE or DONE.
- `a`  input  32  multiplicand, signed two's complement; captured on the accepting edge.
- `b`  input  32  multiplier, signed two's complement; captured on the accepting edge.
- `hi`  output  32  product bits [63:32]; registered.
- `lo`  output  32  product bits [31:0]; registered.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse; `hi`/`lo` are valid from this cycle onward.

## Operation
- Internal state:
  - 33-bit accumulator `A`, sign-extended to avoid overflow on M = 0x80000000.
  - 33-bit `M`, sign-extended copy of `a`.
  - 32-bit `Q`, loaded from `b`.
  - 1-bit `q_1`.
  - 6-bit step counter.
- FSM states: IDLE, RUN, DONE.
- IDLE with `start`=1: load A=0, M=sext(a), Q=b, q_1=0, count=0, then go to RUN. Otherwise stay in IDLE.
- RUN, one Booth step per cycle, selected by {Q[0], q_1}:
  - 01: A = A + M
  - 10: A = A - M
  - 00 or 11: A unchanged
  - Then arithmetic right shift of {A, Q, q_1} by 1, using the sign of the updated A. Increment count.
- After the 32nd step: hi = A[31:0], lo = Q (the post-shift values), then go to DONE.
- DONE: `done`=1 for this cycle only.
  - With `start`=1: behave as IDLE-accept (load operands, go to RUN), so back-to-back multiplies are allowed.
  - Otherwise go to IDLE.
- `start` during RUN is ignored. There is no queuing and the operation in flight is unaffected.
- `a`/`b` changes after the accepting edge have no effect on the result.
- `hi`/`lo` hold their last result until the next completion. They are not modified during RUN.
- Reset, including mid-RUN: state IDLE, hi=0, lo=0, busy=0, done=0, counter and internal registers cleared. The in-flight operation is aborted and produces no `done`.
- Reset has priority over `start` on the same edge.

## Timing
- Edge E0: `start` sampled and operands loaded; RUN entered.
- Edges E1..E32: Booth steps. `busy`=1 in the cycles after E0 through E32.
- Edge E32: `hi`/`lo` updated; state becomes DONE.
- Cycle after E32: `done`=1 and `busy`=0.
- Latency: 32 clock cycles from the accepting edge to the result being visible.
- Throughput: one result per 33 cycles with back-to-back `start` in DONE.
- Output values after reset: hi=0x00000000, lo=0x00000000, busy=0, done=0.
- `done` is never high for two consecutive cycles.

## Test plan
- **Small positive:** a=3, b=5, one-cycle `start`.
  - `done` exactly 32 cycles after the accepting edge.
  - hi=0x00000000, lo=0x0000000F.
- **Mixed sign:** a=0xFFFFFFFF (-1), b=1 → hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- **Extremes:**
  - a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
  - a=b=0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001.
- **Busy protection:** start a=7, b=6; pulse `start` with a=9, b=9 in RUN cycle 10; change a/b freely during RUN.
  - Exactly one `done`; hi=0, lo=0x0000002A.
  - Then `start` during the DONE cycle with a=-4, b=5: second `done` 33 cycles after the first; hi=0xFFFFFFFF, lo=0xFFFFFFEC.
- **Reset mid-op:** complete a=2, b=2 (lo=4). Start a=10, b=10, then assert `reset` in RUN cycle 15.
  - Next cycle: hi=lo=0, busy=0.
  - No `done` follows.
  - A new a=10, b=10 gives lo=0x64.
- **Random regression:** at least 1000 random signed pairs, including `start` issued in the DONE state; compare {hi, lo} against a 64-bit signed reference product.
